// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between
// ALU writeback (req0) and load writeback (req1), with a one-cycle write stage.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic [N_REGS-1:0] wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  logic              prio;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [N_REGS-1:0] dec;

  // Grants are purely combinational so a requester learns of acceptance in
  // the same cycle it asks; the pointer only breaks ties.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!hold) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (prio) gnt1 = 1'b1;
        else      gnt0 = 1'b1;
      end
    end
  end

  assign xfer = gnt0 | gnt1;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    if (gnt0) begin
      sel_addr = addr0;
      sel_data = data0;
    end else if (gnt1) begin
      sel_addr = addr1;
      sel_data = data1;
    end
  end

  // Register 0 is hardwired zero, so its enable is never raised.
  always_comb begin
    dec = '0;
    dec[sel_addr] = 1'b1;
    dec[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (gnt0) begin
      prio <= 1'b1;
    end else if (gnt1) begin
      prio <= 1'b0;
    end
  end

  // wr_data deliberately keeps its last value on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      busy  <= xfer;
      wr_en <= xfer ? dec : '0;
      if (xfer) wr_data <= sel_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter: reset, single writer,
// round-robin, $zero writes, hold, same-address race and mid-operation reset.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        req0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic        gnt0;
  logic        req1;
  logic [4:0]  addr1;
  logic [31:0] data1;
  logic        gnt1;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] bank [32];

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .N_REGS(32)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural register bank fed by the write port.
  always @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (wr_en[r]) bank[r] <= wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; hold = 1'b0;
    req0 = 1'b1; addr0 = 5'd1; data0 = 32'h1111_1111;
    req1 = 1'b0; addr1 = 5'd2; data1 = 32'h2222_2222;
    tick(); tick();
    checks++; if (wr_en !== 32'h0) begin errors++; $display("[TB] FAIL reset_wr_en got %h exp %h", wr_en, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_wr_data got %h exp %h", wr_data, 32'h0); end
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL reset_gnt_single got %b exp 10", {gnt0, gnt1}); end
    req1 = 1'b1;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL reset_gnt_both got %b exp 10", {gnt0, gnt1}); end
    reset = 1'b1;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL post_reset_first_gnt got %b exp 10", {gnt0, gnt1}); end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (wr_en !== 32'h0000_0002) begin errors++; $display("[TB] FAIL post_reset_wr_en got %h exp %h", wr_en, 32'h2); end
    checks++; if (wr_data !== 32'h1111_1111) begin errors++; $display("[TB] FAIL post_reset_wr_data got %h exp %h", wr_data, 32'h1111_1111); end
    tick();
    checks++; if ({busy, wr_en} !== 33'h0) begin errors++; $display("[TB] FAIL idle_after_write got busy=%b wr_en=%h exp 0/0", busy, wr_en); end
    checks++; if (wr_data !== 32'h1111_1111) begin errors++; $display("[TB] FAIL idle_wr_data_hold got %h exp %h", wr_data, 32'h1111_1111); end
  endtask

  // Entered with prio=1 (req0 served last); only req0 requests.
  task automatic test_single();
    req0 = 1'b1; addr0 = 5'd5; data0 = 32'h0000_03E8;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL single_gnt got %b exp 10", {gnt0, gnt1}); end
    tick();
    req0 = 1'b0;
    checks++; if (wr_en !== 32'h0000_0020) begin errors++; $display("[TB] FAIL single_wr_en got %h exp %h", wr_en, 32'h20); end
    checks++; if (wr_data !== 32'h0000_03E8) begin errors++; $display("[TB] FAIL single_wr_data got %h exp %h", wr_data, 32'h3E8); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b exp 1", busy); end
    tick();
    checks++; if (wr_en !== 32'h0) begin errors++; $display("[TB] FAIL single_wr_en_clear got %h exp 0", wr_en); end
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; addr0 = 5'd12; data0 = 32'hCAFE_0012;
    tick();
    req0 = 1'b0;
    checks++; if (wr_en !== 32'h0000_1000) begin errors++; $display("[TB] FAIL mid_reset_pre_wr_en got %h exp %h", wr_en, 32'h1000); end
    #1 reset = 1'b0;
    #1;
    checks++; if ({busy, wr_en, wr_data} !== 65'h0) begin errors++; $display("[TB] FAIL mid_reset_async_clear got busy=%b wr_en=%h wr_data=%h exp all 0", busy, wr_en, wr_data); end
    tick();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 5'd3; addr1 = 5'd7;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL mid_reset_prio got %b exp 10", {gnt0, gnt1}); end
  endtask

  // Continues from test_reset_mid with both requesting and prio=0.
  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_en;
    logic [31:0] exp_d;
    data0 = 32'hAAAA_0003; data1 = 32'hBBBB_0007;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if ({gnt0, gnt1} !== exp_g) begin errors++; $display("[TB] FAIL rr_gnt[%0d] got %b exp %b", i, {gnt0, gnt1}, exp_g); end
      tick();
      exp_en = (i % 2 == 0) ? 32'h0000_0008 : 32'h0000_0080;
      exp_d  = (i % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0007;
      checks++; if (wr_en !== exp_en) begin errors++; $display("[TB] FAIL rr_wr_en[%0d] got %h exp %h", i, wr_en, exp_en); end
      checks++; if (wr_data !== exp_d) begin errors++; $display("[TB] FAIL rr_wr_data[%0d] got %h exp %h", i, wr_data, exp_d); end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  // Entered with prio=0.
  task automatic test_zero();
    req1 = 1'b1; addr1 = 5'd0; data1 = 32'hFFFF_FFFF;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("[TB] FAIL zero_gnt got %b exp 01", {gnt0, gnt1}); end
    tick();
    req1 = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy got %b exp 1", busy); end
    checks++; if (wr_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL zero_wr_data got %h exp %h", wr_data, 32'hFFFF_FFFF); end
    checks++; if (wr_en !== 32'h0) begin errors++; $display("[TB] FAIL zero_wr_en got %h exp 0", wr_en); end
    tick();
  endtask

  // prio=0 after the $zero write, so req0 must win first here.
  task automatic test_hold();
    req0 = 1'b1; addr0 = 5'd4; data0 = 32'h0000_0044;
    req1 = 1'b1; addr1 = 5'd6; data1 = 32'h0000_0066;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL hold_first_gnt got %b exp 10", {gnt0, gnt1}); end
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("[TB] FAIL hold_second_gnt got %b exp 01", {gnt0, gnt1}); end
    tick();
    hold = 1'b1;
    #1;
    checks++; if (wr_en !== 32'h0000_0040) begin errors++; $display("[TB] FAIL hold_inflight_wr_en got %h exp %h", wr_en, 32'h40); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_inflight_busy got %b exp 1", busy); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("[TB] FAIL hold_no_gnt[%0d] got %b exp 00", i, {gnt0, gnt1}); end
      tick();
    end
    checks++; if ({busy, wr_en} !== 33'h0) begin errors++; $display("[TB] FAIL hold_idle got busy=%b wr_en=%h exp 0/0", busy, wr_en); end
    hold = 1'b0;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL hold_release_gnt got %b exp 10", {gnt0, gnt1}); end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (wr_en !== 32'h0000_0010) begin errors++; $display("[TB] FAIL hold_release_wr_en got %h exp %h", wr_en, 32'h10); end
    tick();
  endtask

  // Entered with prio=1 (req0 served last).
  task automatic test_same_addr();
    req0 = 1'b1; addr0 = 5'd9; data0 = 32'd100;
    req1 = 1'b1; addr1 = 5'd9; data1 = 32'd200;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("[TB] FAIL race_first_gnt got %b exp 01", {gnt0, gnt1}); end
    tick();
    req1 = 1'b0;
    #1;
    checks++; if (wr_en !== 32'h0000_0200) begin errors++; $display("[TB] FAIL race_first_wr_en got %h exp %h", wr_en, 32'h200); end
    checks++; if (wr_data !== 32'd200) begin errors++; $display("[TB] FAIL race_first_wr_data got %0d exp 200", wr_data); end
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL race_second_gnt got %b exp 10", {gnt0, gnt1}); end
    tick();
    req0 = 1'b0;
    checks++; if (wr_data !== 32'd100) begin errors++; $display("[TB] FAIL race_second_wr_data got %0d exp 100", wr_data); end
    tick();
    checks++; if (bank[9] !== 32'd100) begin errors++; $display("[TB] FAIL race_reg9_final got %0d exp 100", bank[9]); end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    hold = 1'b0;
    req0 = 1'b0; addr0 = '0; data0 = '0;
    req1 = 1'b0; addr1 = '0; data1 = '0;
    for (int r = 0; r < 32; r++) bank[r] = 32'h0;
    test_reset();
    test_single();
    test_reset_mid();
    test_round_robin();
    test_zero();
    test_hold();
    test_same_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32-entry register bank (32 x 32-bit enabled registers) between two writeback requesters: req0 (ALU writeback) and req1 (load writeback).
- Arbitrates round-robin with a valid/grant handshake.
- Decodes the winning address into a one-hot per-register enable vector and drives a registered write data bus.
- Sits between the writeback stage and the register bank enables.

Parameters:
- DATA_W, 32, width of the write data.
- ADDR_W, 5, register address width.
- N_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- hold  input  1  stall; while 1 no grant is issued.
- req0  input  1  requester 0 has a pending write.
- addr0  input  ADDR_W  requester 0 destination register.
- data0  input  DATA_W  requester 0 write data.
- gnt0  output  1  combinational grant to requester 0.
- req1  input  1  requester 1 has a pending write.
- addr1  input  ADDR_W  requester 1 destination register.
- data1  input  DATA_W  requester 1 write data.
- gnt1  output  1  combinational grant to requester 1.
- wr_en  output  N_REGS  registered one-hot enable, one bit per register.
- wr_data  output  DATA_W  registered write data to all registers.
- busy  output  1  registered; 1 in the cycle a write is being presented.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port reset. While reset=0: wr_en=0, wr_data=0, busy=0, priority pointer prio=0 (requester 0 favoured).
- Handshake: a requester holds req/addr/data stable until it sees gnt=1 in the same cycle. A transfer occurs at the rising edge where reqX=1 and gntX=1. The requester may present a new request or drop req at that edge.
- Grant logic (combinational, same cycle as the request), evaluated in this order:
  - hold=1: gnt0=gnt1=0.
  - Only one req high: that requester is granted.
  - Both high: grant requester prio.
  - At most one gnt high in any cycle.
- Priority pointer: on every transfer, prio becomes the index of the requester not just served. With no transfer, prio is unchanged.
- Write stage (1-cycle latency):
  - On the edge after transfer cycle T, during cycle T+1: wr_data = granted data; wr_en = one-hot(granted addr); busy=1.
  - The register bank captures on the edge ending T+1.
  - With no transfer in T: wr_en=0, busy=0, wr_data holds its previous value.
- Register 0 (MIPS $zero): a request to addr 0 is arbitrated and granted normally and counts for priority. wr_en stays all-zero for that write, while busy=1 and wr_data still update.
- Back-to-back: a transfer may occur every cycle, so the write port sustains one write per cycle. With both requesting continuously, grants alternate 0,1,0,1 starting from the current prio.
- Same address from both requesters in one cycle: no merging. The winner writes first; the loser writes on a later cycle, so the loser's data is the final value.
- hold mid-sequence: a transfer already accepted completes its write cycle regardless of hold. Pending requests wait. prio is frozen while hold=1.
- Reset mid-operation: an in-flight write is dropped (wr_en cleared immediately and asynchronously). prio returns to 0. Requesters re-present after reset deasserts.
- No X propagation: when req is low, its addr/data are ignored.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req0=1 -> wr_en=0, busy=0, wr_data=0, gnt0/gnt1 still follow the arbitration rules combinationally. Release reset -> first grant goes to req0 when both request.
- Single writer: req0=1, addr0=5, data0=32'h0000_03E8 for one transfer -> gnt0=1 that cycle; next cycle wr_en=32'h0000_0020, wr_data=32'h0000_03E8, busy=1; following cycle wr_en=0.
- Contention/round-robin: req0 and req1 held high with addr0=3, addr1=7 over 4 transfers -> grant order 0,1,0,1; wr_en sequence 0x8, 0x80, 0x8, 0x80 on consecutive cycles.
- $zero write: req1=1, addr1=0, data1=32'hFFFF_FFFF -> gnt1=1; next cycle busy=1, wr_data=32'hFFFF_FFFF, wr_en=0; prio moves to 0.
- Hold: both requesting, assert hold for 3 cycles just after a grant to req1 -> the accepted write still appears, no gnt during hold, prio stays 0; after release, req0 is granted first.
- Same-address race: addr0=addr1=9, data0=100, data1=200, prio=1 -> req1 writes 200 first, req0 writes 100 next cycle; register 9 ends at 100.
